// File: rtl/fp16_mul_arbiter.sv
// Two-requester round-robin front end for one shared, registered fp16 multiplier.
// One pipeline stage tracks the in-flight op; one result slot per requester.
module fp16_mul_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             res0_valid,
    output logic             res1_valid,
    input  logic             res0_ready,
    input  logic             res1_ready,
    output logic [15:0]      res0_data,
    output logic [15:0]      res1_data,
    output logic [15:0]      mul_A,
    output logic [15:0]      mul_B,
    input  logic [15:0]      mul_out,
    output logic [CNT_W-1:0] issue_cnt
);

    logic             stg_vld;
    logic             stg_tag;
    logic             last_gnt;
    logic             slot0_vld;
    logic             slot1_vld;
    logic [15:0]      slot0_data;
    logic [15:0]      slot1_data;
    logic [CNT_W-1:0] cnt;

    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;
    logic wr0;
    logic wr1;

    // A slot being drained this cycle frees room for the next result.
    assign elig0 = req0_valid & ~(stg_vld & ~stg_tag)
                 & (~slot0_vld | res0_ready);
    assign elig1 = req1_valid & ~(stg_vld & stg_tag)
                 & (~slot1_vld | res1_ready);

    // last_gnt=1 means req1 won last, so req0 takes a tie.
    assign gnt0 = RESETn & elig0 & (~elig1 | last_gnt);
    assign gnt1 = RESETn & elig1 & (~elig0 | ~last_gnt);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        mul_A = 16'h0000;
        mul_B = 16'h0000;
        unique case (1'b1)
            gnt0: begin
                mul_A = req0_a;
                mul_B = req0_b;
            end
            gnt1: begin
                mul_A = req1_a;
                mul_B = req1_b;
            end
            default: begin
                mul_A = 16'h0000;
                mul_B = 16'h0000;
            end
        endcase
    end

    assign wr0 = stg_vld & ~stg_tag;
    assign wr1 = stg_vld & stg_tag;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            stg_vld    <= 1'b0;
            stg_tag    <= 1'b0;
            last_gnt   <= 1'b1;
            slot0_vld  <= 1'b0;
            slot1_vld  <= 1'b0;
            slot0_data <= 16'h0000;
            slot1_data <= 16'h0000;
            cnt        <= '0;
        end else begin
            stg_vld <= gnt0 | gnt1;
            if (gnt0 | gnt1) begin
                stg_tag  <= gnt1;
                last_gnt <= gnt1;
                cnt      <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // A landing result wins over a same-cycle drain.
            slot0_vld <= wr0 | (slot0_vld & ~res0_ready);
            slot1_vld <= wr1 | (slot1_vld & ~res1_ready);
            if (wr0) slot0_data <= mul_out;
            if (wr1) slot1_data <= mul_out;
        end
    end

    assign res0_valid = slot0_vld;
    assign res1_valid = slot1_vld;
    assign res0_data  = slot0_data;
    assign res1_data  = slot1_data;
    assign issue_cnt  = cnt;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Randomised and directed bench for fp16_mul_arbiter against a
// queue-based reference model and a behavioural fp16 multiplier.
module tb_fp16_mul_arbiter;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic        res0_ready = 1'b0;
    logic        res1_ready = 1'b0;
    logic [15:0] req0_a = '0;
    logic [15:0] req0_b = '0;
    logic [15:0] req1_a = '0;
    logic [15:0] req1_b = '0;
    logic [15:0] mul_out = '0;

    logic        req0_ready, req1_ready, res0_valid, res1_valid;
    logic [15:0] res0_data, res1_data, mul_A, mul_B, issue_cnt;

    logic        w_req0_ready, w_req1_ready, w_res0_valid, w_res1_valid;
    logic [15:0] w_res0_data, w_res1_data, w_mul_A, w_mul_B;
    logic [3:0]  w_cnt;

    always #5 CLK = ~CLK;

    fp16_mul_arbiter dut (
        .CLK(CLK), .RESETn(RESETn),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res1_valid(res1_valid),
        .res0_ready(res0_ready), .res1_ready(res1_ready),
        .res0_data(res0_data), .res1_data(res1_data),
        .mul_A(mul_A), .mul_B(mul_B), .mul_out(mul_out),
        .issue_cnt(issue_cnt)
    );

    fp16_mul_arbiter #(.CNT_W(4)) dut_w4 (
        .CLK(CLK), .RESETn(RESETn),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(w_req0_ready), .req1_ready(w_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(w_res0_valid), .res1_valid(w_res1_valid),
        .res0_ready(res0_ready), .res1_ready(res1_ready),
        .res0_data(w_res0_data), .res1_data(w_res1_data),
        .mul_A(w_mul_A), .mul_B(w_mul_B), .mul_out(mul_out),
        .issue_cnt(w_cnt)
    );

    // Normal-range fp16 multiply, round to nearest even.
    function automatic logic [15:0] fmul(input logic [15:0] a,
                                         input logic [15:0] b);
        int          e;
        logic [21:0] m;
        logic [9:0]  f;
        logic        up;
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        m = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        if (m[21]) e++;
        else m = m << 1;
        f  = m[20:11];
        up = m[10] && ((m[9:0] != 10'd0) || m[11]);
        if (up) begin
            if (f == 10'h3ff) begin
                f = '0;
                e++;
            end else begin
                f = f + 10'd1;
            end
        end
        return {a[15] ^ b[15], e[4:0], f};
    endfunction

    always @(posedge CLK) mul_out <= fmul(mul_A, mul_B);

    function automatic logic [15:0] rnd16();
        logic [4:0] e;
        logic [9:0] f;
        e = 5'($urandom_range(10, 20));
        f = 10'($urandom);
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    typedef struct packed {
        logic        tag;
        logic [15:0] p;
    } op_t;

    op_t         pipe[$];
    logic [15:0] expq0[$];
    logic [15:0] expq1[$];
    logic        m_sv[2];
    logic [15:0] m_sd[2];
    logic        m_last;
    int unsigned m_cnt;
    logic [15:0] last0, last1;
    logic [7:0]  hist;
    int          gn0, gn1;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        expq0.delete();
        expq1.delete();
        m_sv   = '{1'b0, 1'b0};
        m_sd   = '{16'h0, 16'h0};
        m_last = 1'b1;
        m_cnt  = 0;
    endtask

    task automatic step();
        logic        busy0, busy1, e0, e1, g0, g1, rr0, rr1;
        logic [15:0] ea, eb, p;
        op_t         op;
        @(negedge CLK);
        busy0 = 1'b0;
        busy1 = 1'b0;
        foreach (pipe[k]) begin
            if (pipe[k].tag) busy1 = 1'b1;
            else busy0 = 1'b1;
        end
        rr0 = res0_ready;
        rr1 = res1_ready;
        e0 = RESETn && req0_valid && !busy0 && (!m_sv[0] || rr0);
        e1 = RESETn && req1_valid && !busy1 && (!m_sv[1] || rr1);
        if (e0 && e1) begin
            g0 = m_last;
            g1 = !m_last;
        end else begin
            g0 = e0;
            g1 = e1;
        end
        ea = g0 ? req0_a : (g1 ? req1_a : 16'h0);
        eb = g0 ? req0_b : (g1 ? req1_b : 16'h0);
        chk("ready", {req0_ready, req1_ready}, {g0, g1});
        chk("mul_ab", {mul_A, mul_B}, {ea, eb});
        chk("res_v", {res0_valid, res1_valid}, {m_sv[0], m_sv[1]});
        chk("res_d", {res0_data, res1_data}, {m_sd[0], m_sd[1]});
        chk("cnt", issue_cnt, 16'(m_cnt));
        chk("w4_ctl",
            {w_req0_ready, w_req1_ready, w_res0_valid, w_res1_valid,
             w_mul_A, w_mul_B},
            {g0, g1, m_sv[0], m_sv[1], ea, eb});
        chk("w4_d", {w_res0_data, w_res1_data}, {m_sd[0], m_sd[1]});
        chk("w4_cnt", w_cnt, 4'(m_cnt));
        if (res0_valid && rr0) begin
            chk("sb0_q", expq0.size() != 0, 1);
            if (expq0.size() != 0) chk("sb0", res0_data, expq0.pop_front());
            last0 = res0_data;
        end
        if (res1_valid && rr1) begin
            chk("sb1_q", expq1.size() != 0, 1);
            if (expq1.size() != 0) chk("sb1", res1_data, expq1.pop_front());
            last1 = res1_data;
        end
        hist = {hist[5:0], req0_ready, req1_ready};
        if (req0_ready && req0_valid) gn0++;
        if (req1_ready && req1_valid) gn1++;
        p = g0 ? fmul(req0_a, req0_b) : fmul(req1_a, req1_b);
        if (g0) expq0.push_back(p);
        if (g1) expq1.push_back(p);
        @(posedge CLK);
        if (RESETn) begin
            if (m_sv[0] && rr0) m_sv[0] = 1'b0;
            if (m_sv[1] && rr1) m_sv[1] = 1'b0;
            if (pipe.size() != 0) begin
                op = pipe.pop_front();
                m_sv[op.tag] = 1'b1;
                m_sd[op.tag] = op.p;
            end
            if (g0 || g1) begin
                pipe.push_back('{tag: g1, p: p});
                m_last = g1;
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic go_reset();
        RESETn = 1'b0;
        model_reset();
        step();
        RESETn = 1'b1;
        gn0 = 0;
        gn1 = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        last0 = '0;
        last1 = '0;
        hist  = '0;
        gn0   = 0;
        gn1   = 0;
        model_reset();
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        go_reset();
        step();

        // Single op
        go_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_a = 16'h3C00;
        req0_b = 16'h4000;
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        step();
        chk("r029_grant", hist[1:0], 2'b10);
        req0_valid = 1'b0;
        run(3);
        chk("r029_data", last0, 16'h4000);
        chk("r029_cnt", issue_cnt, 16'd1);

        // Tie and alternation
        go_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 16'h3C00;
        req0_b = 16'h3C00;
        req1_a = 16'h4000;
        req1_b = 16'h4000;
        run(4);
        chk("r030_seq", hist, 8'b10_01_10_01);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        run(3);
        chk("r030_d0", last0, 16'h3C00);
        chk("r030_d1", last1, 16'h4400);

        // Back-pressure on slot 1
        go_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = rnd16();
        req0_b = rnd16();
        req1_a = rnd16();
        req1_b = rnd16();
        res0_ready = 1'b1;
        res1_ready = 1'b0;
        run(10);
        chk("r031_g1", gn1, 1);
        chk("r031_g0", gn0, 5);
        res1_ready = 1'b1;
        step();
        chk("r031_resume", hist[0], 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        run(3);

        // Streaming one requester through its slot
        go_reset();
        req0_valid = 1'b1;
        res0_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_a = rnd16();
            req0_b = rnd16();
            step();
        end
        chk("r032_cnt", issue_cnt, 16'd4);
        req0_valid = 1'b0;
        run(3);
        chk("r032_q", expq0.size(), 0);

        // Reset while an op is in flight
        go_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        go_reset();
        run(3);
        chk("r033_v", {res0_valid, res1_valid}, 2'b00);
        chk("r033_cnt", issue_cnt, 16'd0);

        // Narrow counter wrap
        go_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        run(17);
        chk("r034_w4", w_cnt, 4'd1);
        chk("r034_cnt", issue_cnt, 16'd17);

        // Random traffic
        go_reset();
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            res0_ready = ($urandom_range(0, 9) < 7);
            res1_ready = ($urandom_range(0, 9) < 6);
            req0_a = rnd16();
            req0_b = rnd16();
            req1_a = rnd16();
            req1_b = rnd16();
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        run(4);
        chk("rand_q", expq0.size() + expq1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
